// File: rtl/op_pipe_alu.sv
// rtl/op_pipe_alu.sv - pipelined shift/compare/select operator unit with accumulator
module op_pipe_alu #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_flag,
    output logic             out_err,
    output logic [WIDTH-1:0] acc_q
);
    localparam int               SHW     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [3:0] OP_PASS    = 4'd0;
    localparam logic [3:0] OP_SHL     = 4'd1;
    localparam logic [3:0] OP_SHR     = 4'd2;
    localparam logic [3:0] OP_SRA     = 4'd3;
    localparam logic [3:0] OP_EQ      = 4'd4;
    localparam logic [3:0] OP_NE      = 4'd5;
    localparam logic [3:0] OP_WEQ     = 4'd6;
    localparam logic [3:0] OP_WNE     = 4'd7;
    localparam logic [3:0] OP_SEL     = 4'd8;
    localparam logic [3:0] OP_ACC_LD  = 4'd9;
    localparam logic [3:0] OP_ACC_SHL = 4'd10;
    localparam logic [3:0] OP_ACC_SRA = 4'd11;

    // Amounts of WIDTH or more saturate instead of wrapping the SHW-bit field.
    function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] amt,
                                                  input logic             left,
                                                  input logic             arith);
        logic [SHW-1:0] s;
        logic           big;
        s   = amt[SHW-1:0];
        big = (amt >= WIDTH_V);
        if (left)
            shift_op = big ? '0 : (v << s);
        else if (arith)
            shift_op = big ? {WIDTH{v[WIDTH-1]}} : $unsigned($signed(v) >>> s);
        else
            shift_op = big ? '0 : (v >> s);
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] flag_q;
    logic [STAGES-1:0] err_q;
    logic [WIDTH-1:0]  res_q [STAGES];

    logic [WIDTH-1:0]  c_res;
    logic [WIDTH-1:0]  acc_nx;
    logic [WIDTH-1:0]  acc_d;
    logic              c_flag;
    logic              c_err;
    logic              is_cmp;
    logic              acc_we;
    logic              weq;
    logic              accept;

    assign accept = in_valid & in_ready;

    always_comb begin
        c_res  = '0;
        c_flag = 1'b0;
        c_err  = 1'b0;
        is_cmp = 1'b0;
        acc_we = 1'b0;
        acc_nx = acc_q;
        weq    = (((in_a ^ in_b) & ~in_mask) == '0);
        case (in_op)
            OP_PASS:    c_res = in_a;
            OP_SHL:     c_res = shift_op(in_a, in_b, 1'b1, 1'b0);
            OP_SHR:     c_res = shift_op(in_a, in_b, 1'b0, 1'b0);
            OP_SRA:     c_res = shift_op(in_a, in_b, 1'b0, 1'b1);
            OP_EQ:      begin is_cmp = 1'b1; c_flag = (in_a == in_b); end
            OP_NE:      begin is_cmp = 1'b1; c_flag = (in_a != in_b); end
            OP_WEQ:     begin is_cmp = 1'b1; c_flag = weq;  end
            OP_WNE:     begin is_cmp = 1'b1; c_flag = ~weq; end
            OP_SEL:     c_res = in_sel ? in_a : in_b;
            OP_ACC_LD:  begin acc_we = 1'b1; acc_nx = in_a; end
            OP_ACC_SHL: begin acc_we = 1'b1; acc_nx = shift_op(acc_q, in_b, 1'b1, 1'b0); end
            OP_ACC_SRA: begin acc_we = 1'b1; acc_nx = shift_op(acc_q, in_b, 1'b0, 1'b1); end
            default:    c_err = 1'b1;
        endcase
        if (is_cmp)
            c_res = {{(WIDTH-1){1'b0}}, c_flag};
        if (acc_we)
            c_res = acc_nx;
        acc_d = (accept && acc_we) ? acc_nx : acc_q;
    end

    // A stage may move if any stage at or after it is empty, or the consumer takes a result.
    always_comb begin : advance
        logic hole;
        adv  = '0;
        hole = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hole   = hole | ~v_q[k];
            adv[k] = hole;
        end
    end

    assign in_ready = adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            flag_q <= '0;
            err_q  <= '0;
            acc_q  <= '0;
            for (int k = 0; k < STAGES; k++)
                res_q[k] <= '0;
        end else begin
            acc_q <= acc_d;
            if (adv[0]) begin
                v_q[0] <= accept;
                if (accept) begin
                    res_q[0]  <= c_res;
                    flag_q[0] <= c_flag;
                    err_q[0]  <= c_err;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        res_q[k]  <= res_q[k-1];
                        flag_q[k] <= flag_q[k-1];
                        err_q[k]  <= err_q[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_res   = res_q[STAGES-1];
    assign out_flag  = flag_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];
endmodule

// File: tb/tb_op_pipe_alu.sv
// tb/tb_op_pipe_alu.sv - randomized scoreboard bench for op_pipe_alu
module tb_op_pipe_alu;
    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_op = '0;
    logic [W-1:0] in_a = '0, in_b = '0, in_mask = '0;
    logic         in_sel = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_res;
    logic         out_flag;
    logic         out_err;
    logic [W-1:0] acc_q;

    op_pipe_alu #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flag(out_flag), .out_err(out_err),
        .acc_q(acc_q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic         flag;
        logic         err;
        int           cyc;
        bit           timed;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] m_acc = '0;
    int           cyc = 0;
    int           orm = 0;
    int           pat_i = 0;
    bit           pat [6] = '{1, 0, 0, 1, 0, 1};
    bit           stalled_prev = 0;
    logic [W-1:0] prev_res;
    logic         prev_flag, prev_err;

    bit           d_use = 0;
    logic [W-1:0] d_res = '0;
    logic         d_flag = 0, d_err = 0;

    function automatic int floor_div(input int x, input int p);
        return (x >= 0) ? x / p : -((-x + p - 1) / p);
    endfunction

    // Shifts modelled as multiply/divide by 2**s, with s clamped to W for saturation.
    function automatic void ref_eval(input logic [3:0] op, input logic [W-1:0] a, b, m,
                                     input logic sel, input logic [W-1:0] acc,
                                     output logic [W-1:0] res, output logic flag, err,
                                     output logic [W-1:0] nacc);
        int s, p, ua, sa, uacc, sacc;
        s    = (int'(b) > W) ? W : int'(b);
        p    = 1 << s;
        ua   = int'(a);
        sa   = a[W-1] ? ua - (1 << W) : ua;
        uacc = int'(acc);
        sacc = acc[W-1] ? uacc - (1 << W) : uacc;
        res = '0; flag = 0; err = 0; nacc = acc;
        case (op)
            4'd0:  res = a;
            4'd1:  res = W'((ua * p) % (1 << W));
            4'd2:  res = W'(ua / p);
            4'd3:  res = W'(floor_div(sa, p));
            4'd4:  flag = (a == b);
            4'd5:  flag = (a != b);
            4'd6:  flag = ((a | m) == (b | m));
            4'd7:  flag = ((a | m) != (b | m));
            4'd8:  res = sel ? a : b;
            4'd9:  begin nacc = a; res = a; end
            4'd10: begin nacc = W'((uacc * p) % (1 << W)); res = nacc; end
            4'd11: begin nacc = W'(floor_div(sacc, p)); res = nacc; end
            default: err = 1;
        endcase
        if (op >= 4 && op <= 7) res = W'(flag);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            cyc++;
            if (stalled_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_res", out_res, prev_res);
                chk("stall_flag", out_flag, prev_flag);
                chk("stall_err", out_err, prev_err);
            end
            chk("in_ready", in_ready, out_ready | (q.size() < S));
            chk("acc_q", acc_q, m_acc);
            if (q.size() == 0) begin
                chk("idle_valid", out_valid, 0);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                chk("res", out_res, e.res);
                chk("flag", out_flag, e.flag);
                chk("err", out_err, e.err);
                if (e.timed && orm == 0) chk("latency", cyc - e.cyc, S);
            end
            stalled_prev = out_valid && !out_ready;
            prev_res = out_res; prev_flag = out_flag; prev_err = out_err;
            if (in_valid && in_ready) begin
                logic [W-1:0] r, na;
                logic f, er;
                ref_eval(in_op, in_a, in_b, in_mask, in_sel, m_acc, r, f, er, na);
                if (d_use) begin r = d_res; f = d_flag; er = d_err; end
                m_acc = na;
                e.res = r; e.flag = f; e.err = er; e.cyc = cyc; e.timed = (orm == 0);
                q.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (orm)
                0: out_ready = 1'b1;
                1: begin out_ready = pat[pat_i % 6]; pat_i++; end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, m, input logic sel,
                         input bit use_d, input logic [W-1:0] er, input logic ef, ee);
        int n;
        in_op = op; in_a = a; in_b = b; in_mask = m; in_sel = sel;
        d_use = use_d; d_res = er; d_flag = ef; d_err = ee;
        in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 500);
        if (!in_ready) chk("accept_timeout", n, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        d_use = 0;
    endtask

    task automatic rand_op();
        logic [W-1:0] a, b, m;
        a = W'($urandom);
        m = W'($urandom);
        case ($urandom_range(0, 3))
            0: b = W'($urandom);
            1: b = a ^ (m & W'($urandom));
            default: b = W'($urandom_range(0, 9));
        endcase
        issue(4'($urandom_range(0, 15)), a, b, m, 1'($urandom_range(0, 1)), 0, '0, 0, 0);
    endtask

    task automatic drain();
        int n;
        orm = 0;
        n = 0;
        while (q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        chk("drain", q.size(), 0);
    endtask

    logic [3:0]   t_op  [14] = '{4'd1, 4'd3, 4'd2, 4'd2, 4'd3, 4'd1, 4'd6, 4'd6, 4'd8, 4'd8, 4'd9, 4'd10, 4'd10, 4'd11};
    logic [W-1:0] t_a   [14] = '{8'h81, 8'h81, 8'h81, 8'hFF, 8'h80, 8'h01, 8'hA5, 8'hA5, 8'h03, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [W-1:0] t_b   [14] = '{8'h01, 8'h01, 8'h01, 8'h08, 8'h20, 8'h07, 8'hA4, 8'hA4, 8'h09, 8'h09, 8'h00, 8'h02, 8'h03, 8'h10};
    logic [W-1:0] t_m   [14] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic         t_sel [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic [W-1:0] t_res [14] = '{8'h02, 8'hC0, 8'h40, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h00, 8'h03, 8'h09, 8'h01, 8'h04, 8'h20, 8'h00};
    logic         t_flg [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_flag", out_flag, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_acc", acc_q, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            issue(t_op[i], t_a[i], t_b[i], t_m[i], t_sel[i], 1, t_res[i], t_flg[i], 0);
        drain();
        chk("acc_end", acc_q, 0);

        pat_i = 0;
        orm = 1;
        for (int i = 0; i < 6; i++) rand_op();
        drain();

        orm = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            rand_op();
        end
        drain();

        orm = 3;
        issue(4'd9, 8'h55, 8'h00, 8'h00, 0, 1, 8'h55, 0, 0);
        issue(4'd0, 8'h3C, 8'h00, 8'h00, 0, 1, 8'h3C, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_acc", acc_q, 0);
        chk("mid_rst_res", out_res, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        m_acc = '0;
        stalled_prev = 0;
        orm = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(4'd13, 8'h77, 8'h11, 8'h00, 0, 1, 8'h00, 0, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/op_pipe_alu.md
Name: op_pipe_alu

Overview:
- Parametrised, pipelined operator-evaluation unit with valid/ready handshakes on input and output.
- Evaluates logical and arithmetic shifts, equality and wildcard-equality compares, and conditional select, plus an accumulating shift register mode.
- Sits between an operand source and a result consumer in the datapath, with configurable data width and pipeline depth.
- Generalises a fixed single-cycle operator/select evaluation into a backpressured, multi-stage, stateful block.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2).
- STAGES, 2, pipeline register stages between input accept and output (1..4).
- SHW, $clog2(WIDTH), shift-amount field width (derived, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept this cycle.
- in_op  input  4  opcode.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B / shift amount.
- in_mask  input  WIDTH  don't-care mask for wildcard compares (1 = ignore bit).
- in_sel  input  1  select for SEL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_res  output  WIDTH  result.
- out_flag  output  1  compare result (0 for non-compare ops).
- out_err  output  1  reserved opcode was issued.
- acc_q  output  WIDTH  current accumulator value.

Behaviour:
- Reset (async assert, synchronous release by flop design): all stage valid bits 0, out_valid=0, out_res=0, out_flag=0, out_err=0, acc_q=0. in_ready=1 after reset since the pipe is empty.
- Accept: transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Stage advance: stage k advances when it is empty or stage k+1 advances; the last stage advances when out_ready.
- in_ready = !stage0_valid | stage0 advancing. Purely combinational from out_ready and stage valids; no dependency on in_valid.
- Latency: result appears on out_valid exactly STAGES cycles after accept if never stalled.
- Throughput: 1 per cycle with out_ready held high.
- Stall: out_* held stable while out_valid & !out_ready. No bubbles are inserted, and no data is dropped or duplicated.
- Compute: combinational at accept from inputs and current acc_q; the result is then carried through the stages.
- Opcodes:
  - 0 PASS: res=a.
  - 1 SHL: res=a<<s.
  - 2 SHR: res=a>>s (logical).
  - 3 SRA: res=a>>>s (arithmetic, a signed).
  - 4 EQ: flag=(a==b).
  - 5 NE: flag=(a!=b).
  - 6 WEQ: flag=(((a^b)&~mask)==0).
  - 7 WNE: flag = !WEQ.
  - 8 SEL: res = sel ? a : b.
  - 9 ACC_LD: acc<=a, res=a.
  - 10 ACC_SHL: acc<=acc<<s, res=new acc.
  - 11 ACC_SRA: acc<=acc>>>s, res=new acc.
  - 12-15: res=0, flag=0, err=1, acc unchanged.
- Compare ops: res = zero-extended flag.
- Shift amount s = b[SHW-1:0]:
  - If b ≥ WIDTH (any upper bit set or field ≥ WIDTH), shift saturates: SHL/SHR/ACC_SHL give 0; SRA/ACC_SRA give sign fill.
- Accumulator: updated only on the accept cycle of ops 9-11.
  - Back-to-back acc ops chain: the second sees the first's update.
  - acc_q reflects the update one cycle after accept, independent of pipeline stalls.
- Reset mid-operation: all in-flight results are discarded and acc is cleared. No output transfer occurs until new input is accepted after reset release.

Test Plan:
- WIDTH=8, STAGES=2; accept SHL a=8'h81 b=1, then SRA a=8'h81 b=1, then SHR a=8'h81 b=1 with out_ready=1 → out_res 8'h02, 8'hC0, 8'h40 on cycles accept+2, +3, +4.
- SHR a=8'hFF b=8 → 0; SRA a=8'h80 b=8'h20 → 8'hFF; SHL a=8'h01 b=7 → 8'h80.
- WEQ a=8'hA5 b=8'hA4 mask=8'h01 → flag=1, res=8'h01; same with mask=0 → flag=0. SEL sel=1 a=3 b=9 → 3; sel=0 → 9.
- ACC_LD 8'h01, ACC_SHL 2, ACC_SHL 3, ACC_SRA 8'h10 back-to-back → res 8'h01, 8'h04, 8'h20, 8'h00; acc_q ends 0.
- 6 ops issued with out_ready toggled 1,0,0,1,0,1… → all 6 results in order, each exactly once, out_* stable while stalled, in_ready=0 when full.
- Assert rst_n low with 2 results in flight and acc=8'h55 → out_valid=0 and acc_q=0 immediately; opcode 13 after release → res=0, out_err=1.
